fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the pipelined controller/datapath; supplies InstrF, which the controller registers into Decode.
- Owns the PC and a single-outstanding-request handshake to instruction memory, which may insert wait states.
- Holds a small prefetch buffer that absorbs Decode stalls.
- On a taken branch or PC write retiring in Writeback (PCSrcW), redirects to ResultW, flushes the buffer and discards any in-flight fetch.

Parameters:
- ADDR_W, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- BUF_DEPTH, 2, prefetch buffer entries; power of two, >=2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req high.
- imem_ack  in  1  one-cycle acknowledge; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- StallF  in  1  from hazard unit; Decode not accepting, do not pop.
- PCSrcW  in  1  redirect request from controller Writeback stage.
- ResultW  in  ADDR_W  redirect target.
- InstrF  out  32  instruction presented to the controller's Fetch->Decode register.
- InstrValidF  out  1  InstrF holds a real instruction.
- PCPlus8F  out  ADDR_W  address of presented instruction + 8.

Behaviour:
- Reset (asynchronous, reset=0):
  - pc=RESET_PC; buffer empty; state=IDLE; imem_req=0; imem_addr=RESET_PC.
  - InstrF=BUBBLE_INSTR; InstrValidF=0; PCPlus8F=RESET_PC+8.
- States: IDLE, WAIT, DROP.
  - IDLE -> WAIT when free slots (BUF_DEPTH - count) >= 1 and no redirect this cycle. imem_req=1 and imem_addr=pc are registered on the transition.
  - WAIT, imem_ack=1, no redirect:
    - push {imem_rdata, pc}; pc<=pc+4; imem_req<=0; go IDLE.
    - Back-to-back issue is allowed on the following cycle, giving at best one fetch per 2 cycles.
  - WAIT, redirect without ack -> DROP.
  - DROP: imem_req stays high (requests cannot be retracted). On ack, discard data, imem_req<=0, go IDLE.
  - Redirect in the same cycle as an ack (WAIT or DROP): discard data, go IDLE.
- Redirect (PCSrcW=1), in any state:
  - pc<=ResultW; buffer cleared next cycle.
  - InstrValidF=0 and InstrF=BUBBLE_INSTR from the next cycle until a new entry lands.
  - A redirect overrides a simultaneous pop and a simultaneous push.
- Presentation:
  - InstrF/PCPlus8F come combinationally from the buffer head.
  - Buffer empty: InstrF=BUBBLE_INSTR, InstrValidF=0.
- Pop: head is popped at the clock edge when InstrValidF=1, StallF=0 and PCSrcW=0.
- Simultaneous pop and push: count unchanged; ordering preserved.
- Full buffer: no new request is issued. An outstanding request never overflows the buffer, because issue requires a free slot that is reserved for the in-flight fetch.
- Arithmetic: pc+4 and +8 wrap modulo 2^ADDR_W. Low two address bits are passed through unchecked.
- imem_ack in IDLE is ignored (protocol error; an assertion fires in simulation).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined: adds outputs perf_fetched (32) and perf_dropped (32).
  - perf_fetched: saturating count of pushed entries.
  - perf_dropped: saturating count of discarded acks plus flushed buffer entries.
  - Both reset to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - BUBBLE_INSTR = 32'hE1A0_0000 (MOV r0,r0, cond AL; architecturally harmless).
  - State enum {IDLE, WAIT, DROP}.
  - Entry struct {instr[31:0], pc[ADDR_W-1:0]}.
- One sub-module, fetch_buf: a BUF_DEPTH-entry FIFO with push, pop, flush, count, and head outputs. Flush has priority over push and pop.

Test Plan:
- Release reset, memory acks every request after 1 cycle with words 0xE3A01001, 0xE3A02002 -> imem_addr sequence 0x0, 0x4, 0x8; InstrF shows them in order with PCPlus8F 0x8 then 0xC.
- Hold StallF=1 for 10 cycles -> exactly 2 entries are buffered, imem_req stays 0 after the second push, and InstrF holds 0xE3A01001 until StallF drops.
- PCSrcW=1 with ResultW=0x100 while a fetch of 0x8 is in WAIT, ack arriving 3 cycles later -> ack data discarded, next imem_addr=0x100, and no 0x8 instruction is ever presented with InstrValidF=1.
- PCSrcW=1 in the same cycle as imem_ack -> ack data discarded, buffer empty next cycle, InstrF=0xE1A00000, InstrValidF=0.
- Assert reset low mid-WAIT -> imem_req=0 and InstrValidF=0 immediately (asynchronously), and pc=RESET_PC after release.
- With FETCH_PERF_CNT_EN defined, run the redirect scenario -> perf_fetched=2 and perf_dropped=1 at its end.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch stage
package fetch_pkg;

   localparam int FETCH_ADDR_W = 32;

   // MOV r0,r0 (cond AL): harmless filler presented whenever no instruction is ready
   localparam logic [31:0] BUBBLE_INSTR = 32'hE1A0_0000;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } fetchState_t;

   typedef struct packed {
      logic [31:0]             instr;
      logic [FETCH_ADDR_W-1:0] pc;
   } fetchEntry_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - prefetch FIFO of fetched {instr, pc} entries; flush beats push and pop
module fetch_buf
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  fetchEntry_t            pushEntry,
   input  logic                   pop,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count,
   output fetchEntry_t            head
);

   localparam int PTR_W = $clog2(DEPTH);

   fetchEntry_t      mem [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wrPtr] <= pushEntry;
   end

   assign head = mem[rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, single-outstanding imem handshake and prefetch buffer feeding Decode
// Optional saturating perf counters when FETCH_PERF_CNT_EN is defined.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W    = FETCH_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic              StallF,
   input  logic              PCSrcW,
   input  logic [ADDR_W-1:0] ResultW,
   output logic [31:0]       InstrF,
   output logic              InstrValidF,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_dropped,
`endif
   output logic [ADDR_W-1:0] PCPlus8F
);

   localparam int               CNT_W   = $clog2(BUF_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   fetchState_t      state;
   fetchState_t      stateNext;
   logic [ADDR_W-1:0] pc;
   logic             issue;
   logic             push;
   logic             pop;
   logic             flush;
   logic [CNT_W-1:0] count;
   fetchEntry_t      head;
   fetchEntry_t      pushEntry;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= stateNext;
   end

   // Issue only with a free slot; that slot stays reserved for the in-flight fetch
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (!PCSrcW && (count < DEPTH_C)) stateNext = WAIT;
         WAIT:    if (imem_ack) stateNext = IDLE;
                  else if (PCSrcW) stateNext = DROP;
         DROP:    if (imem_ack) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      imem_req    = (state != IDLE);
      issue       = (state == IDLE) && (stateNext == WAIT);
      push        = (state == WAIT) && imem_ack && !PCSrcW;
      flush       = PCSrcW;
      InstrValidF = (count != '0);
      InstrF      = InstrValidF ? head.instr : BUBBLE_INSTR;
      PCPlus8F    = (InstrValidF ? head.pc : pc) + ADDR_W'(8);
      pop         = InstrValidF && !StallF && !PCSrcW;
      pushEntry   = '{instr: imem_rdata, pc: pc};
   end

   // While WAIT, pc still equals imem_addr, so it tags the returning word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc        <= RESET_PC;
         imem_addr <= RESET_PC;
      end else begin
         if (PCSrcW)    pc <= ResultW;
         else if (push) pc <= pc + ADDR_W'(4);
         if (issue) imem_addr <= pc;
      end
   end

   fetch_buf #(
      .DEPTH(BUF_DEPTH)
   ) u_buf (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pushEntry(pushEntry),
      .pop      (pop),
      .flush    (flush),
      .count    (count),
      .head     (head)
   );

`ifdef FETCH_PERF_CNT_EN
   logic        discard;
   logic [32:0] dropSum;

   always_comb begin
      discard = (state != IDLE) && imem_ack && !push;
      dropSum = {1'b0, perf_dropped} + 33'(discard) + (flush ? 33'(count) : 33'd0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else begin
         if (push && (perf_fetched != '1)) perf_fetched <= perf_fetched + 1'b1;
         perf_dropped <= dropSum[32] ? '1 : dropSum[31:0];
      end
   end
`endif

   ackInIdle: assert property (@(posedge clk) disable iff (!reset) !(imem_ack && (state == IDLE)));

endmodule
